// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared encodings and helpers for the round-robin arbiter around the shared mux4.
// State codes and select codes are fixed so they can be matched against other blocks.
package mux4_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StTurn  = 2'd2
    } arb_state_e;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    // First set request scanning ptr, ptr+1, ... with 2-bit wrap; returns ptr if none set.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4.sv
// Shared 4:1 single-bit multiplexer; s selects a/b/c/d.
module mux4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] s,
    output logic       out
);

    always_comb begin
        out = a;
        unique case (s)
            SEL_A: out = a;
            SEL_B: out = b;
            SEL_C: out = c;
            SEL_D: out = d;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux4 among four 1-bit requesters, with a per-grant
// hold limit and a dead TURN cycle between grants.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       y,
    output logic       y_valid,
    output logic       busy
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    arb_state_e state_q;
    logic [1:0] ptr_q;
    logic [3:0] hold_cnt_q;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic       y_q;
    logic       y_valid_q;
    logic       busy_q;
    logic       mux_y;
    logic [1:0] winner;

    assign winner = rr_pick(req, ptr_q);

    mux4 u_mux4 (
        .out (mux_y),
        .a   (din[0]),
        .b   (din[1]),
        .c   (din[2]),
        .d   (din[3]),
        .s   (sel_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= 2'd0;
            hold_cnt_q <= 4'd0;
            gnt_q      <= 4'b0000;
            sel_q      <= SEL_A;
            y_q        <= 1'b0;
            y_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Data path captures every GRANT cycle; y holds otherwise.
            y_valid_q <= (state_q == StGrant);
            if (state_q == StGrant) begin
                y_q <= mux_y;
            end

            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        state_q    <= StGrant;
                        gnt_q      <= onehot4(winner);
                        sel_q      <= winner;
                        hold_cnt_q <= 4'd0;
                        busy_q     <= 1'b1;
                    end
                end
                StGrant: begin
                    // sel_q is the current owner for the whole grant.
                    if (req[sel_q] && (hold_cnt_q < HOLD_LAST)) begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                    end else begin
                        state_q <= StTurn;
                        gnt_q   <= 4'b0000;
                        ptr_q   <= sel_q + 2'd1;
                        busy_q  <= 1'b0;
                    end
                end
                StTurn: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (HOLD_MAX=4) with hand-computed expectations.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       y_valid;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Packs {gnt, busy, y_valid} for compact status checks.
    function automatic int status();
        return int'({gnt, busy, y_valid});
    endfunction

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        din     = 4'b0000;

        // 1. Reset and idle
        tick();
        tick();
        chk("rst_gnt", int'(gnt), 'b0000);
        chk("rst_sel", int'(sel), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_yv_busy", int'({busy, y_valid}), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_status", status(), 0);
        end

        // 2. Single requester c, held for two sampling edges
        req = 4'b0100;
        din = 4'b0100;
        tick();
        chk("c_grant1", status(), {4'b0100, 1'b1, 1'b0});
        chk("c_sel", int'(sel), 2);
        tick();
        chk("c_grant2", status(), {4'b0100, 1'b1, 1'b1});
        chk("c_y1", int'(y), 1);
        req = 4'b0000;
        tick();
        chk("c_turn", status(), {4'b0000, 1'b0, 1'b1});
        chk("c_y2", int'(y), 1);
        tick();
        chk("c_idle", status(), 0);
        chk("c_sel_hold", int'(sel), 2);
        chk("c_y_hold", int'(y), 1);

        // ptr is 3: with a and d requesting, d wins
        req = 4'b1001;
        din = 4'b0000;
        tick();
        chk("ptr3_pick_d", int'(gnt), 'b1000);
        chk("ptr3_sel", int'(sel), 3);
        req = 4'b0000;
        tick();
        chk("d_turn", int'(gnt), 0);
        tick();
        chk("d_idle", status(), 0);

        // 3. Hold limit on a lone requester a
        req = 4'b0001;
        din = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_gnt", int'(gnt), 'b0001);
        end
        tick();
        chk("hold_turn", int'({gnt, busy}), 0);
        chk("hold_turn_y", int'({y, y_valid}), 'b11);
        tick();
        chk("hold_idle", status(), 0);
        tick();
        chk("hold_regrant", int'(gnt), 'b0001);
        req = 4'b0000;
        tick();
        tick();

        // 4. Fairness from reset with all four requesting
        reset_n = 1'b0;
        #1;
        chk("rst2_status", status(), 0);
        tick();
        reset_n = 1'b1;
        req = 4'b1111;
        din = 4'b1010;
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("fair_gnt", int'(gnt), 1 << (g % 4));
                if (k == 0) begin
                    chk("fair_sel", int'(sel), g % 4);
                end
            end
            tick();
            chk("fair_turn", int'({gnt, busy}), 0);
            chk("fair_turn_y", int'({y, y_valid}), {din[g % 4], 1'b1});
            tick();
            chk("fair_idle", status(), 0);
        end

        // 5. Pointer wrap: grant d, release, then b and d request
        req = 4'b1000;
        tick();
        chk("wrap_d", int'(gnt), 'b1000);
        req = 4'b0000;
        tick();
        tick();
        req = 4'b1010;
        din = 4'b0010;
        tick();
        chk("wrap_pick_b", int'(gnt), 'b0010);

        // 6. Asynchronous reset in the 2nd GRANT cycle
        tick();
        chk("mid_before", status(), {4'b0010, 1'b1, 1'b1});
        chk("mid_before_y", int'(y), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_status", status(), 0);
        chk("async_sel", int'(sel), 0);
        tick();
        reset_n = 1'b1;
        req = 4'b1000;
        tick();
        chk("post_rst_d", int'(gnt), 'b1000);
        chk("post_rst_sel", int'(sel), 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
